regfile_wr_scoreboard: RTL and testbench

//  Parametrised write-port controller for the MIPS register file: pending-write scoreboard plus one-hot write-enable decoder.

---
 rtl/regfile_wr_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_wr_scoreboard.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_scoreboard.sv
// rtl/regfile_wr_scoreboard.sv - pending-write scoreboard and one-hot write-enable decoder for the register file
module regfile_wr_scoreboard #(
   parameter int ADDR_W    = 5,
   parameter bit ZERO_HARD = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    issue_valid,
   input  logic [ADDR_W-1:0]       issue_addr,
   output logic                    issue_ready,
   input  logic                    wb_valid,
   input  logic [ADDR_W-1:0]       wb_addr,
   input  logic [ADDR_W-1:0]       rs_addr,
   input  logic [ADDR_W-1:0]       rt_addr,
   output logic                    rs_busy,
   output logic                    rt_busy,
   output logic [(2**ADDR_W)-1:0]  we_onehot,
   output logic [(2**ADDR_W)-1:0]  busy,
   output logic [ADDR_W:0]         pending_cnt,
   output logic                    wb_orphan
);

   localparam int NREGS = 2**ADDR_W;

   logic [NREGS-1:0] busy_q, busy_d;
   logic [NREGS-1:0] we_q, we_d;
   logic [ADDR_W:0]  cnt_q, cnt_d;
   logic             orphan_q, orphan_d;

   logic wb_en;
   logic issue_set;
   logic wb_clr;

   // Register 0 is invisible to the scoreboard when it is hard-wired
   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return ZERO_HARD && (a == '0);
   endfunction

   // Hazard, acceptance and transition qualifiers; no writeback bypass into issue_ready
   always_comb begin
      issue_ready = !busy_q[issue_addr] || is_zero(issue_addr);
      wb_en       = wb_valid && !is_zero(wb_addr);
      issue_set   = issue_valid && issue_ready && !is_zero(issue_addr);
      wb_clr      = wb_en && busy_q[wb_addr];
      rs_busy     = busy_q[rs_addr] && !is_zero(rs_addr) && !(wb_valid && (wb_addr == rs_addr));
      rt_busy     = busy_q[rt_addr] && !is_zero(rt_addr) && !(wb_valid && (wb_addr == rt_addr));
   end

   // Next state: writeback clears first so a same-cycle set on an orphan address wins
   always_comb begin
      busy_d   = busy_q;
      we_d     = '0;
      orphan_d = wb_en && !busy_q[wb_addr];
      cnt_d    = cnt_q + {{ADDR_W{1'b0}}, issue_set} - {{ADDR_W{1'b0}}, wb_clr};
      if (wb_en) begin
         busy_d[wb_addr] = 1'b0;
         we_d[wb_addr]   = 1'b1;
      end
      if (issue_set) begin
         busy_d[issue_addr] = 1'b1;
      end
      if (reset) begin
         busy_d   = '0;
         we_d     = '0;
         orphan_d = 1'b0;
         cnt_d    = '0;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      busy_q   <= busy_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      orphan_q <= orphan_d;
   end

   assign busy        = busy_q;
   assign we_onehot   = we_q;
   assign pending_cnt = cnt_q;
   assign wb_orphan   = orphan_q;

endmodule

// File: tb/tb_regfile_wr_scoreboard.sv
// tb/tb_regfile_wr_scoreboard.sv - randomized scoreboard bench for regfile_wr_scoreboard
module tb_regfile_wr_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance: ADDR_W=5, ZERO_HARD=1
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0, wb_valid = 1'b0;
   logic [4:0]  issue_addr = '0, wb_addr = '0, rs_addr = '0, rt_addr = '0;
   logic        issue_ready, rs_busy, rt_busy, wb_orphan;
   logic [31:0] we_onehot, busy;
   logic [5:0]  pending_cnt;

   regfile_wr_scoreboard #(.ADDR_W(5), .ZERO_HARD(1'b1)) dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
      .we_onehot(we_onehot), .busy(busy), .pending_cnt(pending_cnt), .wb_orphan(wb_orphan)
   );

   // small instances share one stimulus: B has ZERO_HARD=1, C has ZERO_HARD=0
   logic       s_iv = 1'b0, s_wv = 1'b0;
   logic [2:0] s_ia = '0, s_wa = '0;
   logic       b_ready, b_rs, b_rt, b_orphan, c_ready, c_rs, c_rt, c_orphan;
   logic [7:0] b_we, b_busy, c_we, c_busy;
   logic [3:0] b_cnt, c_cnt;

   regfile_wr_scoreboard #(.ADDR_W(3), .ZERO_HARD(1'b1)) dut_b (
      .clk(clk), .reset(reset),
      .issue_valid(s_iv), .issue_addr(s_ia), .issue_ready(b_ready),
      .wb_valid(s_wv), .wb_addr(s_wa),
      .rs_addr(s_ia), .rt_addr(s_wa), .rs_busy(b_rs), .rt_busy(b_rt),
      .we_onehot(b_we), .busy(b_busy), .pending_cnt(b_cnt), .wb_orphan(b_orphan)
   );

   regfile_wr_scoreboard #(.ADDR_W(3), .ZERO_HARD(1'b0)) dut_c (
      .clk(clk), .reset(reset),
      .issue_valid(s_iv), .issue_addr(s_ia), .issue_ready(c_ready),
      .wb_valid(s_wv), .wb_addr(s_wa),
      .rs_addr(s_ia), .rt_addr(s_wa), .rs_busy(c_rs), .rt_busy(c_rt),
      .we_onehot(c_we), .busy(c_busy), .pending_cnt(c_cnt), .wb_orphan(c_orphan)
   );

   typedef struct {
      logic [31:0] busy;
      logic [31:0] we;
      logic [5:0]  cnt;
      logic        orphan;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mbusy[32];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // monitor: registered outputs appear #1 after each edge following a stimulus cycle
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", busy, e.busy);
            chk("pending_cnt", pending_cnt, e.cnt);
            chk("we_onehot", we_onehot, e.we);
            chk("wb_orphan", wb_orphan, e.orphan);
         end
      end
   end

   // one stimulus cycle: drive, check combinational outputs, advance the model, queue the expectation
   task automatic step(input bit rst, input bit iv, input logic [4:0] ia,
                       input bit wv, input logic [4:0] wa,
                       input logic [4:0] rs, input logic [4:0] rt);
      exp_t e;
      bit   ready, wen;
      reset = rst; issue_valid = iv; issue_addr = ia;
      wb_valid = wv; wb_addr = wa; rs_addr = rs; rt_addr = rt;
      #1;
      ready = !mbusy[ia] || (ia == 0);
      chk("issue_ready", issue_ready, ready);
      chk("rs_busy", rs_busy, mbusy[rs] && rs != 0 && !(wv && wa == rs));
      chk("rt_busy", rt_busy, mbusy[rt] && rt != 0 && !(wv && wa == rt));
      e.we = '0;
      e.orphan = 1'b0;
      if (rst) begin
         foreach (mbusy[i]) mbusy[i] = 1'b0;
      end else begin
         wen = wv && wa != 0;
         e.orphan = wen && !mbusy[wa];
         if (wen) begin
            e.we = 32'd1 << wa;
            mbusy[wa] = 1'b0;
         end
         if (iv && ready && ia != 0) mbusy[ia] = 1'b1;
      end
      e.cnt = '0;
      for (int i = 0; i < 32; i++) begin
         e.busy[i] = mbusy[i];
         if (mbusy[i]) e.cnt = e.cnt + 6'd1;
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   initial begin
      int busy_list[$];
      logic [4:0] ia, wa;
      foreach (mbusy[i]) mbusy[i] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1, 0, 0, 0, 0, 0, 0);
      // reset in the middle of live reservations
      step(0, 1, 5, 0, 0, 0, 0);
      step(0, 1, 9, 0, 0, 5, 9);
      step(1, 1, 11, 1, 5, 5, 9);
      step(0, 0, 0, 0, 0, 5, 9);
      // reserve and retire
      step(0, 1, 7, 0, 0, 7, 0);
      step(0, 0, 0, 1, 7, 7, 7);
      step(0, 0, 0, 0, 0, 7, 0);
      // same-cycle WAW stall then retry
      step(0, 1, 3, 0, 0, 0, 0);
      step(0, 1, 3, 1, 3, 3, 0);
      step(0, 1, 3, 0, 0, 3, 0);
      step(0, 0, 0, 1, 3, 0, 0);
      // zero register
      step(0, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      // forwarding then orphan writeback, then orphan with same-address issue
      step(0, 1, 12, 0, 0, 0, 0);
      step(0, 0, 0, 1, 12, 12, 12);
      step(0, 0, 0, 1, 12, 12, 0);
      step(0, 1, 20, 1, 20, 20, 0);
      step(0, 0, 0, 1, 20, 0, 0);
      // fill every non-zero register, then every issue stalls
      for (int r = 1; r < 32; r++) step(0, 1, 5'(r), 0, 0, 5'(r), 0);
      for (int r = 1; r < 32; r += 6) step(0, 1, 5'(r), 0, 0, 5'(r), 5'(r));
      step(0, 1, 4, 1, 4, 4, 4);
      step(0, 1, 4, 0, 0, 4, 0);
      // randomized traffic, writebacks biased toward pending registers
      for (int n = 0; n < 800; n++) begin
         busy_list.delete();
         for (int i = 1; i < 32; i++) if (mbusy[i]) busy_list.push_back(i);
         ia = 5'($urandom_range(0, 31));
         if (busy_list.size() > 0 && $urandom_range(0, 9) < 8)
            wa = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
         else
            wa = 5'($urandom_range(0, 31));
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, ia,
              $urandom_range(0, 2) != 0, wa,
              ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
              5'($urandom_range(0, 31)));
      end
      step(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);

      // small instances: fill 0..7, then stall, then writeback r0
      for (int k = 0; k < 8; k++) begin
         s_iv = 1'b1; s_ia = 3'(k);
         @(negedge clk);
      end
      s_iv = 1'b0;
      chk("b_pending_cnt", b_cnt, 7);
      chk("b_busy", b_busy, 8'hFE);
      chk("c_pending_cnt", c_cnt, 8);
      chk("c_busy", c_busy, 8'hFF);
      s_iv = 1'b1; s_ia = 3'd3;
      #1;
      chk("b_ready_r3", b_ready, 0);
      chk("c_ready_r3", c_ready, 0);
      s_ia = 3'd0;
      #1;
      chk("b_ready_r0", b_ready, 1);
      chk("c_ready_r0", c_ready, 0);
      s_iv = 1'b0; s_wv = 1'b1; s_wa = 3'd0;
      @(negedge clk);
      s_wv = 1'b0;
      chk("b_we_r0", b_we, 8'h00);
      chk("b_orphan_r0", b_orphan, 0);
      chk("c_we_r0", c_we, 8'h01);
      chk("c_busy_r0", c_busy, 8'hFE);
      chk("c_cnt_r0", c_cnt, 7);
      @(negedge clk);
      chk("c_we_pulse", c_we, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
